// File: rtl/onchip_mem_pattern_master_if.sv
// Avalon-MM bus between the pattern master and the single-port on-chip memory.
interface onchip_mem_pattern_master_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   avm_address;
    logic [DATA_W/8-1:0] avm_byteenable;
    logic                avm_chipselect;
    logic                avm_write;
    logic [DATA_W-1:0]   avm_writedata;
    logic [DATA_W-1:0]   avm_readdata;

    modport master (
        output avm_address, avm_byteenable, avm_chipselect, avm_write, avm_writedata,
        input  avm_readdata
    );

    modport slave (
        input  avm_address, avm_byteenable, avm_chipselect, avm_write, avm_writedata,
        output avm_readdata
    );
endinterface

// File: rtl/onchip_mem_pattern_master.sv
// Pattern fill / read-back checker for a 1-cycle-latency on-chip memory.
// Word i of a run carries seed + i at address base_addr + i (wrapping).
module onchip_mem_pattern_master #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    input  logic [DATA_W-1:0] seed,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] first_err_data,
    onchip_mem_pattern_master_if.master avm
);

    typedef enum logic [1:0] {IDLE, FILL, CHECK, DRAIN} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    idx_q, idx_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                cs_q, cs_d;
    logic                wr_q, wr_d;
    logic [DATA_W/8-1:0] be_q, be_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic [15:0]         err_q, err_d;
    logic [ADDR_W-1:0]   ferr_addr_q, ferr_addr_d;
    logic [DATA_W-1:0]   ferr_data_q, ferr_data_d;
    logic                cmp_v_q, cmp_v_d;
    logic [DATA_W-1:0]   exp_data_q, exp_data_d;
    logic [ADDR_W-1:0]   exp_addr_q, exp_addr_d;
    logic                last_word;
    logic                compare_en;

    assign last_word  = (idx_q == cnt_q - CNT_W'(1));
    // A read issued last cycle is compared now unless the run is being aborted.
    assign compare_en = cmp_v_q && !abort;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start && word_count != '0) state_d = mode ? CHECK : FILL;
            FILL:    if (abort || last_word) state_d = IDLE;
            CHECK:   if (abort) state_d = IDLE;
                     else if (last_word) state_d = DRAIN;
            DRAIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cs_d        = 1'b0;
        wr_d        = 1'b0;
        done_d      = 1'b0;
        err_d       = err_q;
        ferr_addr_d = ferr_addr_q;
        ferr_data_d = ferr_data_q;
        cmp_v_d     = 1'b0;
        exp_data_d  = exp_data_q;
        exp_addr_d  = exp_addr_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d       = word_count;
                    idx_d       = '0;
                    addr_d      = base_addr;
                    wdata_d     = seed;
                    err_d       = '0;
                    ferr_addr_d = '0;
                    ferr_data_d = '0;
                    if (word_count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        cs_d = 1'b1;
                        wr_d = !mode;
                    end
                end
            end
            FILL: begin
                if (!abort) begin
                    if (last_word) begin
                        done_d = 1'b1;
                    end else begin
                        cs_d    = 1'b1;
                        wr_d    = 1'b1;
                        idx_d   = idx_q + CNT_W'(1);
                        addr_d  = addr_q + ADDR_W'(1);
                        wdata_d = wdata_q + DATA_W'(1);
                    end
                end
            end
            CHECK: begin
                // The word on the bus this cycle is the one whose readdata arrives next cycle.
                cmp_v_d    = !abort;
                exp_data_d = wdata_q;
                exp_addr_d = addr_q;
                if (!abort && !last_word) begin
                    cs_d    = 1'b1;
                    idx_d   = idx_q + CNT_W'(1);
                    addr_d  = addr_q + ADDR_W'(1);
                    wdata_d = wdata_q + DATA_W'(1);
                end
            end
            DRAIN: begin
                done_d = !abort;
            end
            default: ;
        endcase
        if (compare_en && avm.avm_readdata != exp_data_q) begin
            if (err_q != '1) err_d = err_q + 16'd1;
            if (err_q == '0) begin
                ferr_addr_d = exp_addr_q;
                ferr_data_d = avm.avm_readdata;
            end
        end
    end

    assign busy_d = (state_d != IDLE);
    assign be_d   = cs_d ? '1 : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cs_q        <= 1'b0;
            wr_q        <= 1'b0;
            be_q        <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= '0;
            ferr_addr_q <= '0;
            ferr_data_q <= '0;
            cmp_v_q     <= 1'b0;
            exp_data_q  <= '0;
            exp_addr_q  <= '0;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cs_q        <= cs_d;
            wr_q        <= wr_d;
            be_q        <= be_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            ferr_addr_q <= ferr_addr_d;
            ferr_data_q <= ferr_data_d;
            cmp_v_q     <= cmp_v_d;
            exp_data_q  <= exp_data_d;
            exp_addr_q  <= exp_addr_d;
        end
    end

    assign busy               = busy_q;
    assign done               = done_q;
    assign err_count          = err_q;
    assign first_err_addr     = ferr_addr_q;
    assign first_err_data     = ferr_data_q;
    assign avm.avm_address    = addr_q;
    assign avm.avm_byteenable = be_q;
    assign avm.avm_chipselect = cs_q;
    assign avm.avm_write      = wr_q;
    assign avm.avm_writedata  = wdata_q;

endmodule

// File: tb/tb_onchip_mem_pattern_master.sv
// Scoreboard bench: expected bus accesses are queued by the stimulus, a negedge monitor checks them.
module tb_onchip_mem_pattern_master;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [9:0]  base_addr = '0;
    logic [10:0] word_count = '0;
    logic [31:0] seed = '0;
    logic        abort = 1'b0;
    logic        busy, done;
    logic [15:0] err_count;
    logic [9:0]  first_err_addr;
    logic [31:0] first_err_data;

    logic        poke = 1'b0;
    logic [9:0]  poke_addr = '0;
    logic [31:0] poke_data = '0;
    logic [31:0] mem [1024];

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic        wr;
        logic [9:0]  addr;
        logic [31:0] data;
    } acc_t;
    acc_t exp_q[$];

    onchip_mem_pattern_master_if #(.ADDR_W(10), .DATA_W(32)) avm ();

    onchip_mem_pattern_master #(.ADDR_W(10), .DATA_W(32), .CNT_W(11)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .base_addr(base_addr), .word_count(word_count), .seed(seed), .abort(abort),
        .busy(busy), .done(done), .err_count(err_count),
        .first_err_addr(first_err_addr), .first_err_data(first_err_data),
        .avm(avm)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (poke) begin
            mem[poke_addr] <= poke_data;
        end else if (avm.avm_chipselect) begin
            if (avm.avm_write) mem[avm.avm_address] <= avm.avm_writedata;
            else               avm.avm_readdata <= mem[avm.avm_address];
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && avm.avm_chipselect) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_access_addr", {54'd0, avm.avm_address}, 64'h1_0000_0000);
            end else begin
                acc_t e;
                e = exp_q.pop_front();
                chk("bus_write_flag", {63'd0, avm.avm_write}, {63'd0, e.wr});
                chk("bus_addr", {54'd0, avm.avm_address}, {54'd0, e.addr});
                chk("bus_be", {60'd0, avm.avm_byteenable}, 64'hF);
                if (e.wr) chk("bus_wdata", {32'd0, avm.avm_writedata}, {32'd0, e.data});
            end
        end
    end

    task automatic push_range(input logic wr, input logic [9:0] b, input int unsigned n, input logic [31:0] s);
        for (int unsigned i = 0; i < n; i++) begin
            acc_t e;
            e.wr   = wr;
            e.addr = b + 10'(i);
            e.data = s + i;
            exp_q.push_back(e);
        end
    endtask

    task automatic push_one(input logic wr, input logic [9:0] a, input logic [31:0] d);
        acc_t e;
        e.wr   = wr;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Drives start for one cycle; returns 1 ns after the sampling edge.
    task automatic issue(input logic m, input logic [9:0] b, input logic [10:0] n, input logic [31:0] s);
        @(negedge clk);
        start = 1'b1; mode = m; base_addr = b; word_count = n; seed = s;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int exp_cycles);
        int k;
        k = 1;
        while (!done && k < 3000) begin
            @(posedge clk); #1;
            k++;
        end
        chk({nm, "_done_seen"}, {63'd0, done}, 64'd1);
        chk({nm, "_done_latency"}, 64'(k), 64'(exp_cycles));
        @(posedge clk); #1;
        chk({nm, "_done_pulse_end"}, {63'd0, done}, 64'd0);
        chk({nm, "_busy_after"}, {63'd0, busy}, 64'd0);
    endtask

    task automatic do_poke(input logic [9:0] a, input logic [31:0] d);
        @(negedge clk);
        poke = 1'b1; poke_addr = a; poke_data = d;
        @(negedge clk);
        poke = 1'b0;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_busy"}, {63'd0, busy}, 64'd0);
        chk({nm, "_done"}, {63'd0, done}, 64'd0);
        chk({nm, "_err"}, {48'd0, err_count}, 64'd0);
        chk({nm, "_ferr_addr"}, {54'd0, first_err_addr}, 64'd0);
        chk({nm, "_ferr_data"}, {32'd0, first_err_data}, 64'd0);
        chk({nm, "_cs"}, {63'd0, avm.avm_chipselect}, 64'd0);
        chk({nm, "_wr"}, {63'd0, avm.avm_write}, 64'd0);
        chk({nm, "_addr"}, {54'd0, avm.avm_address}, 64'd0);
        chk({nm, "_be"}, {60'd0, avm.avm_byteenable}, 64'd0);
        chk({nm, "_wdata"}, {32'd0, avm.avm_writedata}, 64'd0);
    endtask

    initial begin
        #3;
        chk_all_zero("reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // 1: wrapping FILL
        push_one(1'b1, 10'h3FE, 32'h0000_1000);
        push_one(1'b1, 10'h3FF, 32'h0000_1001);
        push_one(1'b1, 10'h000, 32'h0000_1002);
        push_one(1'b1, 10'h001, 32'h0000_1003);
        issue(1'b0, 10'h3FE, 11'd4, 32'h0000_1000);
        chk("t1_busy", {63'd0, busy}, 64'd1);
        wait_done("t1", 5);

        // 2: clean CHECK
        push_range(1'b0, 10'h3FE, 4, 32'h0);
        issue(1'b1, 10'h3FE, 11'd4, 32'h0000_1000);
        wait_done("t2", 6);
        chk("t2_err", {48'd0, err_count}, 64'd0);

        // 3: one corrupted word
        do_poke(10'h000, 32'hDEAD_BEEF);
        push_range(1'b0, 10'h3FE, 4, 32'h0);
        issue(1'b1, 10'h3FE, 11'd4, 32'h0000_1000);
        wait_done("t3", 6);
        chk("t3_err", {48'd0, err_count}, 64'd1);
        chk("t3_ferr_addr", {54'd0, first_err_addr}, 64'h000);
        chk("t3_ferr_data", {32'd0, first_err_data}, 64'hDEAD_BEEF);

        // 4: zero-length run; also clears error state
        issue(1'b0, 10'h123, 11'd0, 32'h5);
        chk("t4_busy", {63'd0, busy}, 64'd0);
        wait_done("t4", 1);
        chk("t4_err_cleared", {48'd0, err_count}, 64'd0);

        // 6: two errors logged, ignored restart, then async reset mid-CHECK
        push_range(1'b1, 10'h3FE, 8, 32'h0000_2000);
        issue(1'b0, 10'h3FE, 11'd8, 32'h0000_2000);
        wait_done("t6_fill", 9);
        do_poke(10'h000, 32'hBAD0_0000);
        do_poke(10'h001, 32'hBAD0_0001);
        push_range(1'b0, 10'h3FE, 8, 32'h0);
        issue(1'b1, 10'h3FE, 11'd8, 32'h0000_2000);
        @(negedge clk);
        start = 1'b1; mode = 1'b0; base_addr = 10'h200; word_count = 11'd1; seed = 32'h0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("t6_busy", {63'd0, busy}, 64'd1);
        chk("t6_err", {48'd0, err_count}, 64'd2);
        chk("t6_ferr_addr", {54'd0, first_err_addr}, 64'h000);
        chk("t6_ferr_data", {32'd0, first_err_data}, 64'hBAD0_0000);
        #1;
        reset = 1'b1;
        #1;
        chk_all_zero("t6_reset");
        chk("t6_pending_reads", 64'(exp_q.size()), 64'd3);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t6_idle_after_reset", {63'd0, busy}, 64'd0);

        // 5: long FILL aborted on its 10th write, then a fresh run
        push_range(1'b1, 10'h000, 10, 32'hA000_0000);
        issue(1'b0, 10'h000, 11'd1024, 32'hA000_0000);
        repeat (9) @(posedge clk);
        #1;
        chk("t5_tenth_addr", {54'd0, avm.avm_address}, 64'd9);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("t5_cs_low", {63'd0, avm.avm_chipselect}, 64'd0);
        chk("t5_busy_low", {63'd0, busy}, 64'd0);
        chk("t5_no_done", {63'd0, done}, 64'd0);
        @(posedge clk); #1;
        chk("t5_no_done_later", {63'd0, done}, 64'd0);
        push_range(1'b1, 10'h100, 2, 32'h0000_0007);
        issue(1'b0, 10'h100, 11'd2, 32'h0000_0007);
        wait_done("t5_restart", 3);

        repeat (2) @(posedge clk);
        #1;
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
